bs_acc: RTL
===========

Name: bs_acc

Overview:
- Bit-serial shift-accumulator placed directly downstream of the bit-serial multiplier array.
- Consumes one signed partial sum per weight bit plane, MSB plane first, and forms acc = (acc << 1) + bs_in over a runtime-selected weight precision.
- Presents the completed dot-product result to the next stage, the exponent/normalise stage, through a valid/ready handshake.

Parameters:
- IN_WIDTH, 17: width of the signed bit-serial input (the multiplier's output width).
- MAX_W_PREC, 8: maximum number of weight bit planes per result.
- PREC_WIDTH, 4: width of the w_prec input.
- OUT_WIDTH, IN_WIDTH+MAX_W_PREC (25): width of the signed accumulator and result.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; 0 clears all state immediately.
- w_prec, input, PREC_WIDTH: number of bit planes for the next result; sampled only on the first accepted beat.
- in_valid, input, 1: bs_in carries a valid bit-plane partial sum.
- in_ready, output, 1: block accepts bs_in this cycle.
- bs_in, input, IN_WIDTH (signed): bit-plane partial sum.
- out_valid, output, 1: acc_out holds a completed result.
- out_ready, input, 1: downstream consumes acc_out this cycle.
- acc_out, output, OUT_WIDTH (signed): accumulated result.
- busy, output, 1: high while a result is partially accumulated (state ACCUM).

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, acc=0, cnt=0, prec_q=0
  - out_valid=0, acc_out=0, busy=0
  - in_ready=1 once reset releases.
- Effective precision eff_prec = clamp(w_prec):
  - w_prec==0 gives 1.
  - w_prec>MAX_W_PREC gives MAX_W_PREC.
  - eff_prec is latched into prec_q on the first beat.
- Accept condition: beat = in_valid & in_ready.
- Arithmetic:
  - bs_in is sign-extended to OUT_WIDTH.
  - First beat: acc <= sext(bs_in).
  - Later beats: acc <= (acc <<< 1) + sext(bs_in).
  - OUT_WIDTH is sized so overflow is impossible. Worst case is -2^(IN_WIDTH-1) * (2^MAX_W_PREC - 1), which fits.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
    - On a beat: load acc, cnt <= eff_prec-1.
    - If eff_prec==1, go to DONE; otherwise go to ACCUM.
    - No beat: hold.
  - ACCUM: in_ready=1, busy=1, out_valid=0.
    - On a beat: shift-add, cnt <= cnt-1.
    - If cnt==1 at the beat, go to DONE.
    - in_valid low (bubble): hold acc and cnt; bubbles of any length are legal.
  - DONE: out_valid=1, acc_out=acc, in_ready=out_ready.
    - out_ready=1 without a beat: go to IDLE.
    - out_ready=1 with a beat: the result is consumed and the beat is treated as the first beat of the next result (new w_prec sampled, acc reloaded). Next state is ACCUM, or DONE if eff_prec==1.
    - out_ready=0: hold acc_out stable, in_ready=0.
- Latency: out_valid rises the cycle after the last bit-plane beat is accepted.
- Throughput: one bit plane per cycle. Back-to-back results need no idle cycle while out_ready stays high.
- acc_out is registered and changes only on the DONE entry edge. It is 0 after reset.
- w_prec changes mid-result are ignored; prec_q governs the result in flight.
- Reset asserted mid-result discards the partial sum and any undelivered result. No output glitch propagates; outputs go directly to reset values.

Test Plan:
- Reset then w_prec=4, bs_in=1,1,1,1 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th beat, acc_out=15, then IDLE.
- w_prec=3, bs_in=-3,5,-65536 -> acc_out=-12+10-65536=-65538. Also all-extreme w_prec=8, bs_in=-65536 x8 -> acc_out=-16711680 with no overflow.
- w_prec=1, bs_in=-7 -> out_valid next cycle, acc_out=-7. Also w_prec=0 (-> 1) and w_prec=12 (-> 8) clamping checked by beat count before out_valid.
- w_prec=2 beats 3,4 with 3-cycle in_valid bubble between them -> acc_out=10. Hold out_ready=0 for 5 cycles -> out_valid and acc_out=10 stable, in_ready=0. Release -> one transfer.
- Back-to-back: out_ready=1, continuous beats of results (w_prec=2: 1,1) then (w_prec=2: 2,0) -> acc_out=3 then 4 with no idle cycle between out_valid pulses.
- w_prec=4, after 2 beats drive reset=0 asynchronously mid-cycle -> outputs zero immediately. After release, new w_prec=2, 1,2 -> acc_out=4, with no residue from the aborted result.

Source files
------------

// File: rtl/bs_acc_if.sv
// Handshake bundle between the bit-serial multiplier array, bs_acc and the normalise stage.
// The slave modport is the accumulator side; master is the driver/consumer side.
interface bs_acc_if #(
  parameter int unsigned IN_WIDTH   = 17,
  parameter int unsigned MAX_W_PREC = 8,
  parameter int unsigned PREC_WIDTH = 4,
  parameter int unsigned OUT_WIDTH  = IN_WIDTH + MAX_W_PREC
);
  logic [PREC_WIDTH-1:0]       w_prec;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  bs_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] acc_out;
  logic                        busy;

  modport master (
    output w_prec, in_valid, bs_in, out_ready,
    input  in_ready, out_valid, acc_out, busy
  );

  modport slave (
    input  w_prec, in_valid, bs_in, out_ready,
    output in_ready, out_valid, acc_out, busy
  );
endinterface

// File: rtl/bs_acc.sv
// Bit-serial shift-accumulator: acc = (acc << 1) + bs_in over w_prec bit planes, MSB first,
// delivering each finished dot product downstream through a valid/ready handshake.
module bs_acc #(
  parameter int unsigned IN_WIDTH   = 17,
  parameter int unsigned MAX_W_PREC = 8,
  parameter int unsigned PREC_WIDTH = 4,
  parameter int unsigned OUT_WIDTH  = IN_WIDTH + MAX_W_PREC
) (
  input logic   clk,
  input logic   reset,
  bs_acc_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                      state_q;
  logic signed [OUT_WIDTH-1:0] acc_q;
  logic signed [OUT_WIDTH-1:0] acc_out_q;
  logic [PREC_WIDTH-1:0]       cnt_q;
  logic                        out_valid_q;
  logic                        busy_q;

  logic [PREC_WIDTH-1:0]       eff_prec;
  logic signed [OUT_WIDTH-1:0] bs_ext;
  logic signed [OUT_WIDTH-1:0] acc_d;
  logic                        first;
  logic                        last;
  logic                        beat;

  always_comb begin
    eff_prec = bus.w_prec;
    if (bus.w_prec == '0) begin
      eff_prec = PREC_WIDTH'(1);
    end else if (bus.w_prec > PREC_WIDTH'(MAX_W_PREC)) begin
      eff_prec = PREC_WIDTH'(MAX_W_PREC);
    end
  end

  assign bs_ext = {{(OUT_WIDTH - IN_WIDTH){bus.bs_in[IN_WIDTH-1]}}, bus.bs_in};

  // A beat taken in IDLE or DONE always starts a fresh result.
  assign first = (state_q != StAccum);
  assign acc_d = first ? bs_ext : ((acc_q <<< 1) + bs_ext);
  assign last  = first ? (eff_prec == PREC_WIDTH'(1)) : (cnt_q == PREC_WIDTH'(1));

  assign bus.in_ready  = (state_q != StDone) | bus.out_ready;
  assign beat          = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      acc_out_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_d;
      cnt_q <= first ? (eff_prec - PREC_WIDTH'(1)) : (cnt_q - PREC_WIDTH'(1));
      if (last) begin
        state_q     <= StDone;
        acc_out_q   <= acc_d;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        state_q     <= StAccum;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
      end
    end else if ((state_q == StDone) && bus.out_ready) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end
  end

endmodule
